traffic_phase_ctrl: RTL
=======================

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 The block SHALL use clk as its single rising-edge clock and rst as its reset; rst is asynchronous and active-low.
REQ-002 Parameter T_NS_GREEN, default 30, SHALL set the north-south green time in seconds.
REQ-003 Parameter T_EW_GREEN, default 20, SHALL set the east-west green time in seconds.
REQ-004 Parameter T_YELLOW, default 3, SHALL set the yellow time in seconds; T_ALL_RED, default 2, SHALL set the all-red time; T_WALK, default 10, SHALL set the pedestrian walk time; all parameters are 1..99.
REQ-005 The ports SHALL be exactly as follows:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- sec_tick  in  1  one-cycle pulse per second, from the seconds counter
- ped_req  in  1  pedestrian button, level or pulse
- night  in  1  night-mode request (NIGHT_MODE_EN only)
- ns_light  out  3  {R,Y,G}, one-hot
- ew_light  out  3  {R,Y,G}, one-hot
- walk  out  1  pedestrian walk lamp
- ped_ack  out  1  one-cycle pulse when a request is served
- remain_10  out  4  BCD tens of seconds left
- remain_1  out  4  BCD units of seconds left

Function
REQ-006 The FSM states SHALL be NS_GREEN, NS_YELLOW, ALL_RED_1, EW_GREEN, EW_YELLOW, ALL_RED_2 and WALK, plus FLASH when NIGHT_MODE_EN is defined.
REQ-007 The normal cycle SHALL be NS_GREEN -> NS_YELLOW -> ALL_RED_1 -> EW_GREEN -> EW_YELLOW -> ALL_RED_2 -> NS_GREEN; ALL_RED_2 SHALL go to WALK instead when ped_pend=1, and WALK SHALL go to NS_GREEN.
REQ-008 Light outputs SHALL be:
- each green or yellow state: that road shows its colour, the other road shows red
- ALL_RED_1, ALL_RED_2 and WALK: both roads red
- walk=1 only in WALK
REQ-009 On entry to any state, {remain_10,remain_1} SHALL load that state's duration in BCD.
REQ-010 On each sec_tick the count SHALL decrement by one in BCD; units 0 SHALL wrap to 9 with a borrow from the tens digit.
REQ-011 A sec_tick that arrives while the count is 01 SHALL change the state and load the next duration, both visible on the next clock edge; the count SHALL never display 00 outside FLASH.
REQ-012 All outputs SHALL be registered, and a state change SHALL appear on the outputs one cycle after the causing sec_tick.
REQ-013 ped_req=1 outside WALK SHALL set ped_pend; ped_req SHALL be ignored while in WALK.
REQ-014 On the cycle of WALK entry, ped_pend SHALL clear and ped_ack SHALL pulse for exactly one cycle.
REQ-015 A ped_req and a sec_tick in the same cycle SHALL both take effect, and the request SHALL be counted before the ALL_RED_2 exit decision.
REQ-016 No state other than the count-01 exit SHALL change state on a sec_tick, so no green phase can be skipped or shortened.

Reset
REQ-017 While rst=0, the block SHALL hold the following values:
- state = ALL_RED_2
- ns_light = ew_light = R
- walk = 0, ped_ack = 0, ped_pend = 0
- remain = T_ALL_RED in BCD
REQ-018 An assertion of rst in the middle of any phase SHALL force the reset values immediately, without waiting for clk.

Configuration
REQ-019 With NIGHT_MODE_EN defined, the port night SHALL exist and the following SHALL apply:
- night=1 sampled at the exit of ALL_RED_1 or ALL_RED_2 SHALL enter FLASH
- in FLASH, both roads show yellow toggled on every sec_tick, starting lit
- in FLASH, remain SHALL read 00 and walk SHALL be 0
- ped_req SHALL still set ped_pend in FLASH
- night=0 sampled on a sec_tick in FLASH SHALL move to ALL_RED_2 with T_ALL_RED loaded
REQ-020 Without NIGHT_MODE_EN, the night port and the FLASH state SHALL NOT exist, and behaviour SHALL be REQ-006..REQ-016 only.

Structure
REQ-021 Shared package traffic_pkg SHALL hold:
- the state enumeration
- light encodings R=3'b100, Y=3'b010, G=3'b001
- the default durations
REQ-022 The 2-digit BCD load/decrement counter SHALL be implemented as the sub-module bcd_down_counter, with inputs load, value and dec.

Verification
REQ-023 Release reset, send 2 ticks -> NS_GREEN, remain=30, ns=G, ew=R.
REQ-024 From NS_GREEN at 30, send 30 ticks -> NS_YELLOW, remain=03; the count passes 10->09 and 20->19 correctly.
REQ-025 Pulse ped_req during EW_GREEN -> after ALL_RED_2: WALK, walk=1, ped_ack one cycle, remain=10; after 10 ticks: NS_GREEN.
REQ-026 Send ped_req on the same cycle as the final ALL_RED_2 tick -> WALK is entered; send ped_req during WALK -> no second WALK occurs.
REQ-027 Assert rst mid EW_GREEN at remain=07 -> all outputs take their reset values with no clock edge.
REQ-028 With NIGHT_MODE_EN, set night=1 during EW_GREEN -> FLASH after ALL_RED_2 and yellow toggles per tick; set night=0 -> ALL_RED_2, remain=02.

Source files
------------

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Purpose : Shared types and constants for the traffic phase controller:
//           phase enumeration, lamp encodings, default phase durations and a
//           binary-to-BCD helper.
// Config  : NIGHT_MODE_EN adds the FLASH phase to the enumeration.
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int unsigned LIGHT_W = 3;
    localparam int unsigned BCD_W   = 8;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_1 = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_2 = 3'd5,
        WALK      = 3'd6
`ifdef NIGHT_MODE_EN
        , FLASH   = 3'd7
`endif
    } phase_e;

    // Lamp encodings, {R,Y,G}
    localparam logic [LIGHT_W-1:0] LIGHT_R   = 3'b100;
    localparam logic [LIGHT_W-1:0] LIGHT_Y   = 3'b010;
    localparam logic [LIGHT_W-1:0] LIGHT_G   = 3'b001;
    localparam logic [LIGHT_W-1:0] LIGHT_OFF = 3'b000;

    // Default durations in seconds
    localparam int unsigned DEF_T_NS_GREEN = 30;
    localparam int unsigned DEF_T_EW_GREEN = 20;
    localparam int unsigned DEF_T_YELLOW   = 3;
    localparam int unsigned DEF_T_ALL_RED  = 2;
    localparam int unsigned DEF_T_WALK     = 10;

    // Two-digit BCD of a value in 0..99
    function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// -----------------------------------------------------------------------------
// bcd_down_counter
// Purpose : Two-digit BCD countdown register with synchronous load and
//           decrement. Load has priority over decrement; the count holds at 00.
// Ports   : clk       rising-edge clock
//           rst       asynchronous active-low reset (count <= RESET_VAL)
//           load      load value on the next edge
//           value     BCD value to load {tens,units}
//           dec       decrement by one on the next edge
//           count     registered BCD count {tens,units}
// -----------------------------------------------------------------------------
module bcd_down_counter
    import traffic_pkg::*;
#(
    parameter logic [BCD_W-1:0] RESET_VAL = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BCD_W-1:0] value,
    input  logic             dec,
    output logic [BCD_W-1:0] count
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;

    // Next count: load, else BCD decrement with borrow from tens
    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (load) begin
            tens_d  = value[7:4];
            units_d = value[3:0];
        end else if (dec) begin
            if (units_q != 4'd0) begin
                units_d = units_q - 4'd1;
            end else if (tens_q != 4'd0) begin
                tens_d  = tens_q - 4'd1;
                units_d = 4'd9;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens_q  <= RESET_VAL[7:4];
            units_q <= RESET_VAL[3:0];
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign count = {tens_q, units_q};

endmodule

// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
// Purpose : Two-road intersection phase controller with pedestrian walk phase
//           and a BCD seconds-remaining display.
// Config  : NIGHT_MODE_EN adds the night input and the flashing-yellow phase.
// Ports   : clk        rising-edge clock
//           rst        asynchronous active-low reset
//           sec_tick   one-cycle pulse per second
//           ped_req    pedestrian button (level or pulse)
//           night      night-mode request (NIGHT_MODE_EN only)
//           ns_light   north-south lamps {R,Y,G}
//           ew_light   east-west lamps {R,Y,G}
//           walk       pedestrian walk lamp
//           ped_ack    one-cycle pulse on walk-phase entry
//           remain_10  BCD tens of seconds left
//           remain_1   BCD units of seconds left
// -----------------------------------------------------------------------------
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned T_NS_GREEN = DEF_T_NS_GREEN,
    parameter int unsigned T_EW_GREEN = DEF_T_EW_GREEN,
    parameter int unsigned T_YELLOW   = DEF_T_YELLOW,
    parameter int unsigned T_ALL_RED  = DEF_T_ALL_RED,
    parameter int unsigned T_WALK     = DEF_T_WALK
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sec_tick,
    input  logic               ped_req,
`ifdef NIGHT_MODE_EN
    input  logic               night,
`endif
    output logic [LIGHT_W-1:0] ns_light,
    output logic [LIGHT_W-1:0] ew_light,
    output logic               walk,
    output logic               ped_ack,
    output logic [3:0]         remain_10,
    output logic [3:0]         remain_1
);

    phase_e             state_q, state_d;
    logic               ped_pend_q, ped_pend_d;
    logic [LIGHT_W-1:0] ns_q, ns_d;
    logic [LIGHT_W-1:0] ew_q, ew_d;
    logic               walk_q, walk_d;
    logic               ack_q, ack_d;
`ifdef NIGHT_MODE_EN
    logic               flash_q, flash_d;
`endif

    logic               expire;
    logic               cnt_load;
    logic               cnt_dec;
    logic [BCD_W-1:0]   cnt_val;
    logic [BCD_W-1:0]   cnt_q;

    // Phase duration in BCD; FLASH displays 00
    function automatic logic [BCD_W-1:0] phase_dur(input phase_e s);
        case (s)
            NS_GREEN:             return to_bcd(T_NS_GREEN);
            EW_GREEN:             return to_bcd(T_EW_GREEN);
            NS_YELLOW, EW_YELLOW: return to_bcd(T_YELLOW);
            ALL_RED_1, ALL_RED_2: return to_bcd(T_ALL_RED);
            WALK:                 return to_bcd(T_WALK);
            default:              return 8'h00;
        endcase
    endfunction

    // A phase ends only on the tick that arrives at count 01
    assign expire = sec_tick && (cnt_q == 8'h01);

    // Next phase, pedestrian latch and next registered outputs
    always_comb begin
        state_d    = state_q;
        ped_pend_d = ped_pend_q;
        ns_d       = LIGHT_R;
        ew_d       = LIGHT_R;
        walk_d     = 1'b0;
        ack_d      = 1'b0;
`ifdef NIGHT_MODE_EN
        flash_d    = flash_q;
`endif

        // Same-cycle request is visible to the ALL_RED_2 exit decision below
        if (ped_req && (state_q != WALK)) begin
            ped_pend_d = 1'b1;
        end

        case (state_q)
            NS_GREEN:  if (expire) state_d = NS_YELLOW;
            NS_YELLOW: if (expire) state_d = ALL_RED_1;
            ALL_RED_1: begin
                if (expire) begin
`ifdef NIGHT_MODE_EN
                    state_d = night ? FLASH : EW_GREEN;
`else
                    state_d = EW_GREEN;
`endif
                end
            end
            EW_GREEN:  if (expire) state_d = EW_YELLOW;
            EW_YELLOW: if (expire) state_d = ALL_RED_2;
            ALL_RED_2: begin
                if (expire) begin
                    state_d = ped_pend_d ? WALK : NS_GREEN;
`ifdef NIGHT_MODE_EN
                    if (night) state_d = FLASH;
`endif
                end
            end
            WALK:      if (expire) state_d = NS_GREEN;
`ifdef NIGHT_MODE_EN
            FLASH: begin
                if (sec_tick) begin
                    if (!night) state_d = ALL_RED_2;
                    else        flash_d = !flash_q;
                end
            end
`endif
            default:   state_d = ALL_RED_2;
        endcase

        if ((state_d == WALK) && (state_q != WALK)) begin
            ped_pend_d = 1'b0;
            ack_d      = 1'b1;
        end

`ifdef NIGHT_MODE_EN
        // Flashing starts with the lamps lit
        if ((state_d == FLASH) && (state_q != FLASH)) begin
            flash_d = 1'b1;
        end
`endif

        case (state_d)
            NS_GREEN:  ns_d = LIGHT_G;
            NS_YELLOW: ns_d = LIGHT_Y;
            EW_GREEN:  ew_d = LIGHT_G;
            EW_YELLOW: ew_d = LIGHT_Y;
            WALK:      walk_d = 1'b1;
`ifdef NIGHT_MODE_EN
            FLASH: begin
                ns_d = flash_d ? LIGHT_Y : LIGHT_OFF;
                ew_d = flash_d ? LIGHT_Y : LIGHT_OFF;
            end
`endif
            default: ;
        endcase

        // Load on every phase change, otherwise count down on ticks
        cnt_load = (state_d != state_q);
        cnt_val  = phase_dur(state_d);
        cnt_dec  = sec_tick && !cnt_load;
`ifdef NIGHT_MODE_EN
        if (state_q == FLASH) cnt_dec = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ALL_RED_2;
            ped_pend_q <= 1'b0;
            ns_q       <= LIGHT_R;
            ew_q       <= LIGHT_R;
            walk_q     <= 1'b0;
            ack_q      <= 1'b0;
`ifdef NIGHT_MODE_EN
            flash_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ped_pend_q <= ped_pend_d;
            ns_q       <= ns_d;
            ew_q       <= ew_d;
            walk_q     <= walk_d;
            ack_q      <= ack_d;
`ifdef NIGHT_MODE_EN
            flash_q    <= flash_d;
`endif
        end
    end

    bcd_down_counter #(
        .RESET_VAL (to_bcd(T_ALL_RED))
    ) u_remain (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .value (cnt_val),
        .dec   (cnt_dec),
        .count (cnt_q)
    );

    assign ns_light  = ns_q;
    assign ew_light  = ew_q;
    assign walk      = walk_q;
    assign ped_ack   = ack_q;
    assign remain_10 = cnt_q[7:4];
    assign remain_1  = cnt_q[3:0];

endmodule
